// File: rtl/fixed_point_iterative_multiplier_radix.sv
// Iterative fixed-point multiplier retiring k multiplier bits per cycle, with
// selectable rounding, optional saturation and an overflow flag; val/rdy on both sides.
module fixed_point_iterative_multiplier_radix #(
    parameter int unsigned n     = 32,
    parameter int unsigned d     = 16,
    parameter int unsigned sign  = 1,
    parameter int unsigned k     = 2,
    parameter int unsigned round = 0,
    parameter int unsigned sat   = 0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         recv_rdy,
    input  logic         recv_val,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         send_rdy,
    output logic         send_val,
    output logic [n-1:0] c,
    output logic         overflow
);

    localparam int unsigned W     = 2 * n;
    localparam int unsigned Steps = n / k;
    localparam int unsigned CntW  = $clog2(Steps + 1);
    localparam int unsigned RndSh = (d > 0) ? d - 1 : 0;
    localparam logic [W:0]  RndAdd = (round != 0 && d > 0) ? ((W + 1)'(1) << RndSh) : '0;
    localparam logic [n-1:0] UMax = '1;
    localparam logic [n-1:0] SMax = UMax >> 1;
    localparam logic [n-1:0] SMin = ~SMax;
    localparam bit Signed = (sign != 0);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [n-1:0]    mplier_q, mplier_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [n-1:0]    c_q, c_d;
    logic            ovf_q, ovf_d;

    logic            last;
    logic [W-1:0]    pp;
    logic [W-1:0]    sum;
    logic [W:0]      rsum;
    logic [W:0]      r;
    logic            ovf_calc;
    logic [n-1:0]    c_calc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            ovf_q    <= ovf_d;
        end
    end

    // Partial product of the low k multiplier bits; in signed mode the top group's
    // MSB weighs -2^(k-1), so the +2^(k-1) already added is replaced by -2^(k-1).
    always_comb begin
        last = (cnt_q == CntW'(Steps - 1));
        pp   = '0;
        for (int unsigned i = 0; i < k; i++) begin
            if (mplier_q[i]) pp = pp + (mcand_q << i);
        end
        if (Signed && last && mplier_q[k-1]) pp = pp - (mcand_q << k);
        sum = acc_q + pp;
    end

    // Rounding, scaling and range check on the completed 2n-bit product.
    always_comb begin
        rsum = {Signed & sum[W-1], sum} + RndAdd;
        if (Signed) begin
            r        = $signed(rsum) >>> d;
            ovf_calc = !((&r[W:n-1]) || !(|r[W:n-1]));
        end else begin
            r        = rsum >> d;
            ovf_calc = |r[W:n];
        end
        c_calc = r[n-1:0];
        if (sat != 0 && ovf_calc) begin
            if (Signed) c_calc = r[W] ? SMin : SMax;
            else        c_calc = UMax;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        ovf_d    = ovf_q;
        recv_rdy = 1'b0;
        send_val = 1'b0;
        case (state_q)
            StIdle: begin
                recv_rdy = 1'b1;
                if (recv_val) begin
                    mcand_d  = {{n{Signed & a[n-1]}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                acc_d    = sum;
                mcand_d  = mcand_q << k;
                mplier_d = mplier_q >> k;
                cnt_d    = cnt_q + CntW'(1);
                if (last) begin
                    c_d     = c_calc;
                    ovf_d   = ovf_calc;
                    state_d = StDone;
                end
            end
            StDone: begin
                send_val = 1'b1;
                if (send_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign c        = c_q;
    assign overflow = ovf_q;

endmodule

// File: doc/fixed_point_iterative_multiplier_radix.md
Name: fixed_point_iterative_multiplier_radix

Overview:
- Next-generation unpipelined fixed-point iterative multiplier with val/rdy interfaces on both sides.
- Retires k multiplier bits per cycle, so a multiply takes n/k compute cycles.
- Adds selectable rounding, optional saturation and an overflow flag.
- Drop-in where the single-bit-per-cycle multiplier is too slow but a full array multiplier is too large.

Parameters:
- n, 32, operand/result bit width; must be a multiple of k.
- d, 16, fractional bits; 0 <= d < n.
- sign, 1, 1 = both operands two's complement, 0 = unsigned.
- k, 2, multiplier bits consumed per cycle; 1 <= k <= n, n % k == 0.
- round, 0, 0 = truncate (floor), 1 = round half up (add 2^(d-1) before shift).
- sat, 0, 1 = clamp out-of-range results, 0 = wrap (keep low n bits).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- recv_rdy  out  1  block can accept operands
- recv_val  in  1  operands valid
- a  in  n  multiplicand
- b  in  n  multiplier
- send_rdy  in  1  consumer can accept result
- send_val  out  1  result valid
- c  out  n  result
- overflow  out  1  result did not fit in n bits; valid while send_val

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. Sampled on the posedge.
- Reset:
  - state <= IDLE; internal counter, accumulator and operand registers <= 0.
  - Outputs after reset: recv_rdy=1, send_val=0, c=0, overflow=0.
  - Reset asserted in any state aborts the operation in flight; no result is produced.
- States:
  - IDLE: recv_rdy=1, send_val=0. On recv_val at an edge, latch a and b, clear the accumulator and counter, go to CALC.
  - CALC: recv_rdy=0, send_val=0. Each cycle adds the partial product of the low k bits of the remaining multiplier into the accumulator, shifts the multiplicand left by k and the multiplier right by k, and increments the counter.
    - Signed mode: the top k-bit group carries negative weight on its MSB; this correction is applied in the final CALC cycle.
    - After n/k CALC cycles, go to DONE.
  - DONE: recv_rdy=0, send_val=1, c and overflow stable. On send_rdy at an edge go to IDLE.
- Latency: operands accepted at edge t, send_val asserted in the cycle after edge t+n/k. n/k cycles of CALC, then DONE.
- Throughput: one result per n/k+2 cycles when send_rdy is held high. recv_rdy is high only in IDLE; no acceptance during DONE.
- Arithmetic:
  - P = a*b, exact 2n-bit product (signed or unsigned per sign).
  - R = floor((P + (round ? 2^(d-1) : 0)) / 2^d); arithmetic shift when signed.
  - overflow=1 iff R lies outside the n-bit range: signed [-2^(n-1), 2^(n-1)-1], unsigned [0, 2^n-1].
  - c = sat && overflow ? (R > 0 ? max : min) : R[n-1:0].
  - Unsigned min is 0.
  - The rounding add itself must not wrap; use at least 2n+1 bits internally.
- Edge cases:
  - Operand values on a/b outside the acceptance edge are ignored.
  - recv_val and send_rdy may be high in any state; they only act in IDLE and DONE respectively.
  - k=n: a single CALC cycle.
  - d=0 with round=1: no rounding add, since 2^(d-1) is treated as 0.
  - Most-negative times most-negative (signed) sets overflow when d is small; sat then clamps to max.

Test Plan:
- Basic latency and value (n=8, d=4, k=2, sign=1):
  - a=0x18 (1.5), b=0x20 (2.0) -> c=0x30, overflow=0.
  - send_val rises in the cycle after edge t+4 following acceptance at edge t.
  - recv_rdy low from t+1 through DONE.
- Signed operands (same config):
  - a=0xE8 (-1.5), b=0x20 -> c=0xD0.
  - a=0xE8, b=0xE0 (-2.0) -> c=0x30.
  - Both with overflow=0.
- Rounding (n=8, d=4):
  - a=0x01, b=0x08 with round=0 -> c=0x00; with round=1 -> c=0x01.
  - a=0xFF, b=0x08 with round=1 -> c=0x00 (-0.03125 rounds half up to 0).
- Overflow (n=8, d=4, sign=1):
  - a=0x70 (7.0), b=0x40 (4.0), sat=1 -> c=0x7F, overflow=1.
  - sat=0 -> c=0xC0, overflow=1.
  - a=0x90, b=0x40, sat=1 -> c=0x80.
- Backpressure and reset:
  - Hold send_rdy=0 for 5 cycles in DONE -> send_val stays 1, c and overflow unchanged; new recv_val ignored.
  - Assert reset during the 2nd CALC cycle -> next cycle recv_rdy=1, send_val=0, c=0; no stale result appears.
- Sweep: k in {1,2,4,8}, sign in {0,1}, random operands against a golden model.
  - Check result, overflow and CALC length = n/k.
